// File: rtl/slot_tracker.sv
// slot_tracker: tracks in-flight requests in SLOT_COUNT slots.
// The issue stage allocates the lowest free slot and stores a payload there.
// The response path frees a slot by index and gets the payload back one cycle later.
// Per-slot saturating age counters flag requests that stay outstanding too long.
//
// Handshake: an allocation is accepted on a rising edge where alloc_valid and
// alloc_ready are both 1; alloc_ready is combinational (~full & ~flush) and
// never depends on alloc_valid, so the issuer just holds its request until accepted.
module slot_tracker #(
    parameter int SLOT_COUNT = 8,
    parameter int DATA_W     = 32,
    parameter int AGE_W      = 6,
    parameter int IDX_W      = $clog2(SLOT_COUNT),
    parameter int CNT_W      = $clog2(SLOT_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [DATA_W-1:0]     alloc_data,
    output logic [IDX_W-1:0]      alloc_slot,
    input  logic                  free_valid,
    input  logic [IDX_W-1:0]      free_slot,
    output logic                  free_data_valid,
    output logic [DATA_W-1:0]     free_data,
    output logic                  free_err,
    input  logic                  flush,
    input  logic                  stall,
    output logic [SLOT_COUNT-1:0] slot_valid,
    output logic [SLOT_COUNT-1:0] slot_expired,
    output logic [CNT_W-1:0]      count
);

    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    logic [SLOT_COUNT-1:0] slot_valid_q, slot_valid_d;
    logic [AGE_W-1:0]      age_q [SLOT_COUNT];
    logic [AGE_W-1:0]      age_d [SLOT_COUNT];
    logic [DATA_W-1:0]     data_q [SLOT_COUNT];
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  free_data_valid_q, free_data_valid_d;
    logic [DATA_W-1:0]     free_data_q, free_data_d;
    logic                  free_err_q, free_err_d;

    logic                  full;
    logic                  alloc_fire;
    logic [IDX_W-1:0]      alloc_idx;
    logic [SLOT_COUNT-1:0] alloc_oh;
    logic [SLOT_COUNT-1:0] free_oh;
    logic [SLOT_COUNT-1:0] free_clr;
    logic [DATA_W-1:0]     free_payload;
    logic                  free_hit;
    logic                  free_miss;

    assign full        = &slot_valid_q;
    assign alloc_ready = ~full & ~flush;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign alloc_slot  = alloc_idx;

    // Lowest-index free slot; only meaningful while something is free.
    always_comb begin
        logic found;
        alloc_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            if (!slot_valid_q[i] && !found) begin
                alloc_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

    // One-hot decode of the allocation target and the retired slot, plus payload mux.
    always_comb begin
        alloc_oh     = '0;
        free_oh      = '0;
        free_payload = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            alloc_oh[i] = alloc_fire && (alloc_idx == IDX_W'(i));
            if (free_slot == IDX_W'(i)) begin
                free_oh[i]   = 1'b1;
                free_payload = data_q[i];
            end
        end
    end

    // Flush drops a same-cycle free entirely: no data pulse and no error pulse.
    assign free_hit  = free_valid & ~flush & (|(free_oh & slot_valid_q));
    assign free_miss = free_valid & ~flush & ~(|(free_oh & slot_valid_q));
    assign free_clr  = free_hit ? free_oh : '0;

    // Next-state for occupancy, count and the retire/error pulses.
    always_comb begin
        slot_valid_d      = flush ? '0 : ((slot_valid_q & ~free_clr) | alloc_oh);
        count_d           = flush ? '0
                          : (count_q + CNT_W'(alloc_fire) - CNT_W'(free_hit));
        free_data_valid_d = free_hit;
        free_err_d        = free_miss;
        free_data_d       = free_hit ? free_payload : free_data_q;
    end

    // Per-slot age: cleared on flush/alloc/free or while invalid, else saturating count unless stalled.
    always_comb begin
        for (int i = 0; i < SLOT_COUNT; i++) begin
            age_d[i] = age_q[i];
            if (flush || alloc_oh[i] || free_clr[i] || !slot_valid_q[i]) begin
                age_d[i] = '0;
            end else if (!stall && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q      <= '0;
            count_q           <= '0;
            free_data_valid_q <= 1'b0;
            free_data_q       <= '0;
            free_err_q        <= 1'b0;
            for (int i = 0; i < SLOT_COUNT; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            slot_valid_q      <= slot_valid_d;
            count_q           <= count_d;
            free_data_valid_q <= free_data_valid_d;
            free_data_q       <= free_data_d;
            free_err_q        <= free_err_d;
            for (int i = 0; i < SLOT_COUNT; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // Payload storage is written on accept and deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLOT_COUNT; i++) begin
            if (alloc_oh[i]) begin
                data_q[i] <= alloc_data;
            end
        end
    end

    // Expiry flag is a live view of the age counters.
    always_comb begin
        for (int i = 0; i < SLOT_COUNT; i++) begin
            slot_expired[i] = slot_valid_q[i] && (age_q[i] == AGE_MAX);
        end
    end

    assign slot_valid      = slot_valid_q;
    assign count           = count_q;
    assign free_data_valid = free_data_valid_q;
    assign free_data       = free_data_q;
    assign free_err        = free_err_q;

endmodule

// File: tb/tb_slot_tracker.sv
// Bench for slot_tracker: directed scenarios followed by random traffic,
// all checked against an array-based model of the slot table.
module tb_slot_tracker;

    localparam int SC      = 8;
    localparam int DW      = 32;
    localparam int AW      = 3;
    localparam int IW      = 3;
    localparam int CW      = 4;
    localparam int AGE_MAX = 7;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          alloc_valid;
    logic          alloc_ready;
    logic [DW-1:0] alloc_data;
    logic [IW-1:0] alloc_slot;
    logic          free_valid;
    logic [IW-1:0] free_slot;
    logic          free_data_valid;
    logic [DW-1:0] free_data;
    logic          free_err;
    logic          flush;
    logic          stall;
    logic [SC-1:0] slot_valid;
    logic [SC-1:0] slot_expired;
    logic [CW-1:0] count;

    slot_tracker #(
        .SLOT_COUNT(SC),
        .DATA_W    (DW),
        .AGE_W     (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_data     (alloc_data),
        .alloc_slot     (alloc_slot),
        .free_valid     (free_valid),
        .free_slot      (free_slot),
        .free_data_valid(free_data_valid),
        .free_data      (free_data),
        .free_err       (free_err),
        .flush          (flush),
        .stall          (stall),
        .slot_valid     (slot_valid),
        .slot_expired   (slot_expired),
        .count          (count)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: payloads expected on the retire port, in order.
    logic [DW-1:0] exp_q[$];

    // Reference model of the slot table.
    bit            m_valid [SC];
    int            m_age   [SC];
    logic [DW-1:0] m_data  [SC];
    bit            m_fdv;
    bit            m_ferr;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int m_lowest_free();
        for (int i = 0; i < SC; i++) begin
            if (!m_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < SC; i++) n += m_valid[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [SC-1:0] m_valid_vec();
        logic [SC-1:0] v = '0;
        for (int i = 0; i < SC; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [SC-1:0] m_expired_vec();
        logic [SC-1:0] v = '0;
        for (int i = 0; i < SC; i++) v[i] = m_valid[i] && (m_age[i] == AGE_MAX);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SC; i++) begin
            m_valid[i] = 1'b0;
            m_age[i]   = 0;
            m_data[i]  = '0;
        end
        m_fdv  = 1'b0;
        m_ferr = 1'b0;
        exp_q.delete();
    endtask

    // Compare every output with the model for the inputs currently applied.
    task automatic compare_outputs(input bit fl);
        int  lf;
        bit  rdy;
        logic [DW-1:0] exp_d;
        lf  = m_lowest_free();
        rdy = (lf >= 0) && !fl;
        check_eq("slot_valid", slot_valid, m_valid_vec());
        check_eq("count", count, m_count());
        check_eq("free_data_valid", free_data_valid, m_fdv);
        check_eq("free_err", free_err, m_ferr);
        check_eq("slot_expired", slot_expired, m_expired_vec());
        check_eq("alloc_ready", alloc_ready, rdy);
        if (rdy) check_eq("alloc_slot", alloc_slot, lf);
        if (m_fdv) begin
            if (exp_q.size() == 0) begin
                check_eq("free_data_queue_empty", 1, 0);
            end else begin
                exp_d = exp_q.pop_front();
                check_eq("free_data", free_data, exp_d);
            end
        end
    endtask

    // Driver: apply one cycle of inputs, check, clock, then advance the model.
    task automatic step(input bit av, input logic [DW-1:0] ad, input bit fv, input int fs,
                        input bit fl, input bit st);
        int lf;
        bit aacc;
        bit hit;
        bit miss;
        @(negedge clk);
        alloc_valid = av;
        alloc_data  = ad;
        free_valid  = fv;
        free_slot   = IW'(fs);
        flush       = fl;
        stall       = st;
        #1;
        compare_outputs(fl);
        lf   = m_lowest_free();
        aacc = av && !fl && (lf >= 0);
        hit  = fv && !fl && m_valid[fs];
        miss = fv && !fl && !m_valid[fs];
        @(posedge clk);
        #1;
        if (fl) begin
            for (int i = 0; i < SC; i++) begin
                m_valid[i] = 1'b0;
                m_age[i]   = 0;
            end
            m_fdv  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            for (int i = 0; i < SC; i++) begin
                if (m_valid[i] && !st && m_age[i] < AGE_MAX) m_age[i]++;
            end
            if (hit) begin
                exp_q.push_back(m_data[fs]);
                m_valid[fs] = 1'b0;
                m_age[fs]   = 0;
            end
            if (aacc) begin
                m_valid[lf] = 1'b1;
                m_age[lf]   = 0;
                m_data[lf]  = ad;
            end
            m_fdv  = hit;
            m_ferr = miss;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse at an arbitrary point between edges.
    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n       = 1'b0;
        alloc_valid = 1'b0;
        free_valid  = 1'b0;
        flush       = 1'b0;
        stall       = 1'b0;
        #1;
        check_eq("rst_slot_valid", slot_valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_free_data_valid", free_data_valid, 0);
        check_eq("rst_free_data", free_data, 0);
        check_eq("rst_free_err", free_err, 0);
        check_eq("rst_slot_expired", slot_expired, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        alloc_valid = 1'b0;
        alloc_data  = '0;
        free_valid  = 1'b0;
        free_slot   = '0;
        flush       = 1'b0;
        stall       = 1'b0;
        model_reset();
        pulse_reset();
        idle(1);

        // Fill all eight slots back-to-back; a ninth request is held off.
        for (int i = 0; i < SC; i++) step(1, 32'h100 + i, 0, 0, 0, 0);
        check_eq("t1_count_full", count, 8);
        check_eq("t1_ready_full", alloc_ready, 0);
        step(1, 32'h999, 0, 0, 0, 0);
        check_eq("t1_held_count", count, 8);

        // Free slot 3 out of a full table, then reuse it.
        step(0, '0, 1, 3, 0, 0);
        check_eq("t2_fdv", free_data_valid, 1);
        check_eq("t2_free_data", free_data, 32'h103);
        check_eq("t2_slot_valid", slot_valid, 8'hF7);
        step(1, 32'h203, 0, 0, 0, 0);
        check_eq("t2_refill", slot_valid, 8'hFF);

        // Same-cycle allocate and free.
        step(0, '0, 0, 0, 1, 0);
        step(1, 32'h300, 0, 0, 0, 0);
        step(1, 32'h301, 0, 0, 0, 0);
        step(1, 32'h302, 1, 0, 0, 0);
        check_eq("t3_slot_valid", slot_valid, 8'h06);
        check_eq("t3_count", count, 2);
        check_eq("t3_free_data", free_data, 32'h300);

        // Free of an invalid slot.
        step(0, '0, 1, 5, 0, 0);
        check_eq("t4_free_err", free_err, 1);
        check_eq("t4_fdv", free_data_valid, 0);
        check_eq("t4_slot_valid", slot_valid, 8'h06);
        idle(1);
        check_eq("t4_err_pulse_end", free_err, 0);

        // Age expiry without stall.
        step(0, '0, 0, 0, 1, 0);
        step(1, 32'h400, 0, 0, 0, 0);
        idle(6);
        check_eq("t5_not_yet", slot_expired, 8'h00);
        idle(1);
        check_eq("t5_expired", slot_expired, 8'h01);

        // Age expiry with 3 stalled cycles out of 10.
        step(0, '0, 0, 0, 1, 0);
        step(1, 32'h401, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) step(0, '0, 0, 0, 0, (k >= 2 && k <= 4));
        check_eq("t5_stall_not_yet", slot_expired, 8'h00);
        idle(1);
        check_eq("t5_stall_expired", slot_expired, 8'h01);
        idle(3);
        check_eq("t5_saturated", slot_expired, 8'h01);

        // Flush beats a simultaneous free and allocate.
        step(0, '0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 32'h500 + i, 0, 0, 0, 0);
        step(1, 32'h5FF, 1, 1, 1, 0);
        check_eq("t6_slot_valid", slot_valid, 8'h00);
        check_eq("t6_count", count, 0);
        check_eq("t6_fdv", free_data_valid, 0);
        check_eq("t6_ferr", free_err, 0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) step(1, 32'h600 + i, 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        pulse_reset();

        // Random traffic.
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(0, 9) < 7), $urandom,
                 ($urandom_range(0, 9) < 5), $urandom_range(0, SC - 1),
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 3) == 0));
        end
        idle(1);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
